// File: rtl/riot_bus_pkg.sv
// Shared types for the RIOT bus master: host command format and FSM states.
package riot_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_READ     = 2'b01,
    OP_WAIT_IRQ = 2'b10,
    OP_DELAY    = 2'b11
  } riot_op_t;

  typedef struct packed {
    riot_op_t    op;
    logic        ram;
    logic [6:0]  addr;
    logic [7:0]  data;
  } riot_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_WAIT_IRQ,
    ST_DELAY
  } riot_state_t;

  // Commands that produce a response must wait for the response slot to be free.
  function automatic logic needs_rsp(input riot_op_t op);
    return (op == OP_READ) || (op == OP_WAIT_IRQ);
  endfunction

endpackage

// File: rtl/riot_cmd_fifo.sv
// Command queue: pushes on any clock edge, pops only on PHI2 clock-enable edges.
module riot_cmd_fifo
  import riot_bus_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic      clk,
  input  logic      res_n,
  input  logic      ce,
  input  logic      push,
  input  riot_cmd_t push_data,
  input  logic      pop,
  output riot_cmd_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(QDEPTH);

  riot_cmd_t   mem_q [QDEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer bit tells a full queue apart from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && ce && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge res_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!res_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/riot_bus_master.sv
// M6532 RIOT bus initiator: queued host commands become PHI2-aligned bus cycles,
// read captures and IRQ waits, answered through a single-entry response register.
module riot_bus_master
  import riot_bus_pkg::*;
#(
  parameter int QDEPTH      = 4,
  parameter int IRQ_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       ce,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_ram,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       busy,
  output logic [6:0] addr,
  output logic       RW_n,
  output logic [7:0] d_out,
  input  logic [7:0] d_in,
  output logic       RS_n,
  output logic       CS1,
  output logic       CS2_n,
  input  logic       IRQ_n
);
  riot_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  d_out_q, d_out_d, rsp_data_q, rsp_data_d;
  logic        rw_n_q, rw_n_d, rs_n_q, rs_n_d, cs_q, cs_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  riot_cmd_t   push_cmd, head;
  logic        fifo_full, fifo_empty, pop, can_issue, issue_slot;

  assign push_cmd = '{op: riot_op_t'(cmd_op), ram: cmd_ram, addr: cmd_addr, data: cmd_data};

  riot_cmd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .res_n     (res_n),
    .ce        (ce),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A finishing write hands the bus straight to the next command so CS stays asserted.
  assign can_issue  = !fifo_empty && !(needs_rsp(head.op) && rsp_valid_q);
  assign issue_slot = (state_q == ST_IDLE) || (state_q == ST_ACCESS && !rw_n_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    d_out_d       = d_out_q;
    rw_n_d        = rw_n_q;
    rs_n_d        = rs_n_q;
    cs_d          = cs_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    if (rsp_ready) rsp_valid_d = 1'b0;

    if (ce) begin
      case (state_q)
        ST_IDLE, ST_ACCESS: begin
          if (state_q == ST_ACCESS) begin
            cs_d    = 1'b0;
            rw_n_d  = 1'b1;
            state_d = rw_n_q ? ST_CAPTURE : ST_IDLE;
          end
          if (issue_slot && can_issue) begin
            pop = 1'b1;
            case (head.op)
              OP_WRITE, OP_READ: begin
                addr_d  = head.addr;
                rs_n_d  = ~head.ram;
                rw_n_d  = (head.op == OP_READ);
                if (head.op == OP_WRITE) d_out_d = head.data;
                cs_d    = 1'b1;
                state_d = ST_ACCESS;
              end
              OP_WAIT_IRQ: begin
                cnt_d   = 16'(IRQ_TIMEOUT);
                state_d = ST_WAIT_IRQ;
              end
              default: begin
                cnt_d   = {8'h00, head.data};
                state_d = ST_DELAY;
              end
            endcase
          end
        end
        ST_CAPTURE: begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = d_in;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
        ST_WAIT_IRQ: begin
          // An IRQ seen on the expiry edge still wins over the timeout.
          if (!IRQ_n || cnt_q == 16'd1) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = 8'h00;
            rsp_timeout_d = IRQ_n;
            state_d       = ST_IDLE;
          end
          cnt_d = cnt_q - 16'd1;
        end
        ST_DELAY: begin
          if (cnt_q <= 16'd1) state_d = ST_IDLE;
          else                cnt_d   = cnt_q - 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      d_out_q       <= '0;
      rw_n_q        <= 1'b1;
      rs_n_q        <= 1'b1;
      cs_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      d_out_q       <= d_out_d;
      rw_n_q        <= rw_n_d;
      rs_n_q        <= rs_n_d;
      cs_q          <= cs_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign addr        = addr_q;
  assign RW_n        = rw_n_q;
  assign d_out       = d_out_q;
  assign RS_n        = rs_n_q;
  assign CS1         = cs_q;
  assign CS2_n       = ~cs_q;

endmodule
